mem_bus_rr_arbiter: RTL
=======================

# mem_bus_rr_arbiter

Shares the single lowX memory bus among `NUM_REQ` cache-side requesters (icache, dcache, page-table walker, …) with fair round-robin arbitration. Each requester owns a one-entry request slot that captures a single-cycle request pulse. The granted request is held on the bus until memory responds. The block sits between the L1 caches / walker and the lowX memory port, and replaces fixed two-way sharing of the bus.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (≥2, need not be a power of two).
- `TIMEOUT_CYC`, 1024, watchdog limit in cycles; used only with the timeout feature.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in `lowX_req_t [NUM_REQ]`: requests. `valid` is a one-cycle pulse.
- `res_o` out `lowX_res_t [NUM_REQ]`: per-requester response (`valid`, `ready`, `blk`).
- `mem_bus_req_o` out `lowX_req_t`: request to memory.
- `mem_bus_res_i` in `lowX_res_t`: memory response. `valid` is a one-cycle pulse.
- `grant_id_o` out `$clog2(NUM_REQ)`: index currently granted.
- `busy_o` out 1: a request is on the bus.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires (0 without the timeout feature).

## Operation
- **Slot capture:** slot i captures `req_i[i]` at a clock edge when `req_i[i].valid && !pend[i]`.
- **Ready:** `res_o[i].ready = !pend[i]`. A requester issues a new pulse only while ready. A pulse arriving while the slot is pending is dropped; the bench flags this as a protocol error.
- **FSM states:**
  - IDLE: `mem_bus_req_o.valid=0`. If any slot is pending, pick the winner and go to BUSY, loading `grant_q`.
  - BUSY: drive `mem_bus_req_o` from `slot[grant_q]` with `valid=1`. Hold it stable until `mem_bus_res_i.valid`.
- **Response cycle:**
  - `res_o[grant_q].valid=1` and `res_o[grant_q].blk = mem_bus_res_i.blk` combinationally. All other `res_o[j].valid=0`.
  - `pend[grant_q]` clears and `last_q <= grant_q`.
  - If another slot is pending, go directly to BUSY with the new winner; otherwise go to IDLE.
- **Round robin:** search starts at `(last_q+1) mod NUM_REQ` and wraps explicitly for non-power-of-2 `NUM_REQ`. The slot just served is excluded in the response cycle. `last_q` resets to `NUM_REQ-1`, so slot 0 has first priority.
- **Response routing:** `mem_bus_res_i.valid` in IDLE is ignored and not routed to any requester.
- **Reset values:**
  - `mem_bus_req_o = '{rw_size: NO_SIZE, default: 0}`.
  - `res_o[*].valid=0`, `res_o[*].ready=1`, `res_o[*].blk=0`.
  - `grant_id_o=0`, `busy_o=0`, `timeout_o=0`.
  - All `pend` cleared, state IDLE.
- **Reset mid-transaction:** the outstanding request is abandoned. Any later memory response arrives in IDLE and is dropped.

## Timing
- Pulse in cycle T → slot pending from T+1 → `mem_bus_req_o.valid` from T+2 if the bus is idle.
- Response in cycle R → requester sees `res_o.valid` in cycle R (zero latency) and is ready again from R+1.
- Back-to-back grants: the next request is valid in R+1 with no bubble.
- `busy_o` equals (state==BUSY). `grant_id_o = grant_q` and is stable throughout BUSY.
- A capture and a response on different slots in the same cycle are independent. The same slot cannot see both in one cycle, because of the ready rule.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYC-1` with no response, that cycle forces `res_o[grant_q].valid=1` with `blk='0`, pulses `timeout_o`, clears the slot, and follows the normal response transition.
  - A real response in the firing cycle takes precedence; `timeout_o` stays 0.
- Not defined: no counter, `timeout_o` tied 0, BUSY waits indefinitely.

## Structure
- `ceres_param` gets:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} mem_arb_state_e`.
  - `localparam MEM_ARB_NUM_REQ = 3`.
- `lowX_req_t`, `lowX_res_t` and `NO_SIZE` already live there.
- One sub-module, `rr_picker`: combinational; inputs are the pending vector, start pointer and exclude mask; outputs are `found` and `idx`.
- State, slots, counter and muxing stay in the top module.

## Test plan
- **Single request:** pulse `req_i[1]` (addr 0x8000_0040, read) at T → `mem_bus_req_o.valid` at T+2 with addr 0x8000_0040; response blk 0xA5…A5 at T+5 → `res_o[1].valid` at T+5, `ready` back to 1 at T+6.
- **Fairness:** all three slots pending, each response returned 3 cycles after issue → grants in order 0,1,2,0,1,2 with no idle cycle between grants.
- **Wrap, NUM_REQ=3:** last grant 2, slots 0 and 2 pending → slot 0 granted next.
- **Simultaneous capture/response:** slot 0 responding while slot 2 pulses in the same cycle → slot 2 granted at R+2, slot 0 `ready` at R+1.
- **Async reset:** drop `rst_ni` mid-BUSY for 1 cycle, then send a stray `mem_bus_res_i.valid` → all outputs at reset values, no `res_o.valid`.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYC=16`):** no memory response → `timeout_o` and `res_o[g].valid` with blk 0 in the 16th BUSY cycle, then state IDLE.

Source files
------------

// File: rtl/mem_bus_rr_arbiter_pkg.sv
// mem_bus_rr_arbiter_pkg: ceres_param slice holding the lowX bus types and the arbiter state/config
package ceres_param;
    localparam int BLK_W = 64;
    localparam int MEM_ARB_NUM_REQ = 3;

    typedef enum logic [2:0] {
        SIZE_B    = 3'b000,
        SIZE_H    = 3'b001,
        SIZE_W    = 3'b010,
        SIZE_D    = 3'b011,
        SIZE_LINE = 3'b100,
        NO_SIZE   = 3'b111
    } mem_size_e;

    typedef struct packed {
        logic             valid;
        logic             rw;
        mem_size_e        rw_size;
        logic [31:0]      addr;
        logic [BLK_W-1:0] blk;
    } lowX_req_t;

    typedef struct packed {
        logic             valid;
        logic             ready;
        logic [BLK_W-1:0] blk;
    } lowX_res_t;

    typedef enum logic {ARB_IDLE, ARB_BUSY} mem_arb_state_e;
endpackage

// File: rtl/mem_bus_rr_arbiter_picker.sv
// rr_picker: combinational round-robin search over a pending vector, starting at start and wrapping modulo N
module rr_picker #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] pend,
    input  logic [W-1:0] start,
    input  logic [N-1:0] excl,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [N-1:0] cand;

    assign cand = pend & ~excl;

    // Scan offsets from the far end back to start so the closest candidate is written last
    always_comb begin
        int c;
        c = 0;
        found = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(start) + k;
            c = (c >= N) ? c - N : c;
            if (cand[c[W-1:0]]) begin
                found = 1'b1;
                idx = c[W-1:0];
            end
        end
    end
endmodule

// File: rtl/mem_bus_rr_arbiter.sv
// mem_bus_rr_arbiter: round-robin sharing of the lowX memory bus among NUM_REQ one-entry request slots (watchdog under MEM_ARB_TIMEOUT_EN)
module mem_bus_rr_arbiter
    import ceres_param::*;
#(
    parameter int NUM_REQ     = MEM_ARB_NUM_REQ,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  lowX_req_t                  req_i [NUM_REQ],
    output lowX_res_t                  res_o [NUM_REQ],
    output lowX_req_t                  mem_bus_req_o,
    input  lowX_res_t                  mem_bus_res_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam lowX_req_t IDLE_REQ = '{rw_size: NO_SIZE, default: 0};

    mem_arb_state_e     state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d, last_q, last_d, pick_start, pick_idx;
    logic [NUM_REQ-1:0] pend_q, pick_excl;
    lowX_req_t          slot_q [NUM_REQ];
    logic               busy, fire, resp, pick_found, unused_ready;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

`ifdef MEM_ARB_TIMEOUT_EN
    logic [31:0] cnt_q;

    assign fire = busy && !mem_bus_res_i.valid && (cnt_q == 32'(TIMEOUT_CYC - 1));

    // Watchdog restarts on every entry into BUSY and counts while waiting for memory
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (state_d == ARB_BUSY && (!busy || resp)) cnt_q <= '0;
        else if (busy) cnt_q <= cnt_q + 1'b1;
    end
`else
    logic unused_timeout;

    assign fire = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    assign busy         = state_q == ARB_BUSY;
    assign resp         = busy && (mem_bus_res_i.valid || fire);
    assign pick_start   = busy ? wrap_inc(grant_q) : wrap_inc(last_q);
    assign pick_excl    = busy ? (NUM_REQ'(1) << grant_q) : '0;
    assign grant_id_o   = grant_q;
    assign busy_o       = busy;
    assign timeout_o    = fire;
    assign unused_ready = mem_bus_res_i.ready;

    rr_picker #(.N(NUM_REQ), .W(IW)) u_picker (
        .pend  (pend_q),
        .start (pick_start),
        .excl  (pick_excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next state: claim a winner from IDLE, and on a response hand straight over or drop to IDLE
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (!busy || resp) begin
            state_d = pick_found ? ARB_BUSY : ARB_IDLE;
            grant_d = pick_found ? pick_idx : grant_q;
        end
        if (resp) last_d = grant_q;
    end

    // FSM registers; last_q starts at the top slot so slot 0 has first priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Request slots: capture a pulse into an empty slot, free the slot once it is served
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= IDLE_REQ;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (resp && grant_q == IW'(i)) begin
                    pend_q[i] <= 1'b0;
                end else if (req_i[i].valid && !pend_q[i]) begin
                    pend_q[i] <= 1'b1;
                    slot_q[i] <= req_i[i];
                end
            end
        end
    end

    // Drive the granted slot onto the bus and route the response back with zero latency
    always_comb begin
        mem_bus_req_o = IDLE_REQ;
        if (busy) begin
            mem_bus_req_o = slot_q[grant_q];
            mem_bus_req_o.valid = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            res_o[i].valid = resp && grant_q == IW'(i);
            res_o[i].ready = !pend_q[i];
            res_o[i].blk   = (res_o[i].valid && mem_bus_res_i.valid) ? mem_bus_res_i.blk : '0;
        end
    end
endmodule
